blit_addr_seq: RTL and testbench
================================

# blit_addr_seq

Blitter address sequencer: walks a rectangular block of I elements by O lines and presents one memory address per element. Each element is handshaken against the bus, and the line step is applied between lines. It consumes the latched step/mode value set (8-bit step, STEPM1 sign bit, YFRAC half-rate bit) and turns it into a cycle-accurate address stream for the blitter memory interface.

## Interface
Parameters:
- ADDR_W, 20, address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- MasterClock  in  1  system clock; single clock domain.
- RESETL  in  1  synchronous, active-low reset.
- START  in  1  one-cycle start pulse; ignored unless idle.
- ABORT  in  1  terminate the current block.
- ADDR_INIT  in  ADDR_W  first element address.
- INNER_CNT  in  8  elements per line; 0 means 256.
- OUTER_CNT  in  8  lines per block; 0 means 256.
- STEP  in  8  low 8 bits of the line step.
- STEPM1  in  1  step sign bit; the step is the 9-bit two's-complement value {STEPM1,STEP}.
- YFRAC  in  1  half-rate stepping.
- MEM_ACK  in  1  bus accepted the current ADDR.
- ADDR  out  ADDR_W  current element address.
- ADDR_REQ  out  1  ADDR is valid and requests a memory cycle.
- BUSY  out  1  a block is in progress.
- LINE_END  out  1  one-cycle pulse when a line completes.
- DONE  out  1  one-cycle pulse when the block completes normally.

## Operation
- States:
  - IDLE: waits for START.
  - RUN: element accesses.
  - STEP: line-end update.
  - FIN: completion.
- IDLE + START (ABORT low): capture ADDR_INIT, INNER_CNT, OUTER_CNT, STEP, STEPM1, YFRAC; clear the line parity bit; go to RUN. Inputs are not re-sampled mid-block.
- RUN: ADDR_REQ=1 every cycle.
  - MEM_ACK=0: ADDR and the counters hold.
  - MEM_ACK=1 with inner count > 1: ADDR += 1, inner count -= 1.
  - MEM_ACK=1 with inner count == 1: go to STEP, ADDR unchanged.
- STEP (one cycle): ADDR_REQ=0, LINE_END=1.
  - YFRAC=0, or parity=1: ADDR += sext({STEPM1,STEP}).
  - YFRAC=1 and parity=0: ADDR += 1 (no step).
  - Parity toggles.
  - Outer count == 1: go to FIN.
  - Otherwise: outer count -= 1, reload the inner count, go to RUN.
- FIN (one cycle): DONE=1, BUSY=1, then IDLE.
- ABORT high in RUN/STEP/FIN: IDLE on the next edge, no DONE, ADDR holds its last value. ABORT and START together in IDLE: ABORT wins; stay idle.
- START while BUSY is ignored.
- Address wraps modulo 2^ADDR_W in both directions.

## Timing
- Reset values: state IDLE, ADDR=0, ADDR_REQ=0, BUSY=0, LINE_END=0, DONE=0, counters 0, parity 0. Reset mid-block returns to these on the same edge and emits no DONE.
- START sampled at edge 0 drives ADDR_REQ=1, BUSY=1 and ADDR=ADDR_INIT in cycle 1.
- A new ADDR appears in the cycle after each MEM_ACK. The bench may tie MEM_ACK high.
- With MEM_ACK constantly high:
  - each line takes I+1 cycles;
  - LINE_END is asserted in cycle k·(I+1) for line k = 1..O;
  - DONE is asserted in cycle O·(I+1)+1;
  - BUSY is low from cycle O·(I+1)+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package blit_pkg holds:
  - the state enum (IDLE, RUN, STEP, FIN);
  - the ADDR_W default;
  - a function sign-extending the 9-bit step to ADDR_W.
- Sub-module blit_loop_cnt: an 8-bit loadable down-counter where a load of 0 means 256, with an "is one" flag. It is instantiated twice (inner and outer).
- Sign extension and the address adder stay in the top level.

## Test plan
- Reset: drive RESETL low during RUN. Next cycle: ADDR=0, BUSY=0, ADDR_REQ=0, and no DONE ever follows.
- Positive step: ADDR_INIT=0x01000, I=4, O=2, STEP=0x10, STEPM1=0, YFRAC=0, MEM_ACK=1.
  - Addresses issued: 0x01000–0x01003, then 0x01013–0x01016.
  - LINE_END in cycles 5 and 10; DONE in cycle 11.
- Negative step: ADDR_INIT=0x00100, I=2, O=3, {STEPM1,STEP}=0x1F0 (−16).
  - Addresses issued: 0x100, 0x101, 0xF1, 0xF2, 0xE2, 0xE3.
- YFRAC: ADDR_INIT=0, I=1, O=4, STEP=0x40, YFRAC=1.
  - Addresses issued: 0x00000, 0x00001, 0x00041, 0x00042.
- Wrap and zero counts: ADDR_INIT=0xFFFFF, I=0, O=1.
  - Addresses issued: 0xFFFFF, then 0x00000, continuing to 0x000FE (256 requests).
  - DONE in cycle 258.
- Stall and abort: I=4, O=2.
  - Hold MEM_ACK low for 3 cycles after the second element: ADDR and ADDR_REQ stay stable.
  - Then pulse ABORT: BUSY=0 on the next cycle; no LINE_END and no DONE.
  - A subsequent START runs normally.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and helpers for the blitter address sequencer.
package blit_pkg;

    localparam int unsigned ADDR_W_DFLT = 20;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned STEP_W      = 9;
    localparam int unsigned EXT_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_FIN  = 2'd3
    } blit_state_e;

    // Sign-extend the 9-bit {STEPM1,STEP} line step; callers truncate to their address width.
    function automatic logic [EXT_W-1:0] sext_step(input logic [STEP_W-1:0] step);
        return {{(EXT_W-STEP_W){step[STEP_W-1]}}, step};
    endfunction

endpackage

// File: rtl/blit_loop_cnt.sv
// Loadable 8-bit down-counter; a stored 0 stands for 256 and is never decremented past 1.
module blit_loop_cnt
    import blit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/blit_addr_seq.sv
// Blitter address sequencer: walks an inner x outer block, one handshaken address per element.
module blit_addr_seq
    import blit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
    input  logic              MasterClock,
    input  logic              RESETL,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W-1:0] ADDR_INIT,
    input  logic [CNT_W-1:0]  INNER_CNT,
    input  logic [CNT_W-1:0]  OUTER_CNT,
    input  logic [7:0]        STEP,
    input  logic              STEPM1,
    input  logic              YFRAC,
    input  logic              MEM_ACK,
    output logic [ADDR_W-1:0] ADDR,
    output logic              ADDR_REQ,
    output logic              BUSY,
    output logic              LINE_END,
    output logic              DONE
);

    blit_state_e       state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              parity_q, parity_nxt;
    logic [STEP_W-1:0] step_q;
    logic              yfrac_q;
    logic [CNT_W-1:0]  inner_init_q;
    logic              capture;
    logic              inner_load, inner_dec, inner_one;
    logic              outer_load, outer_dec, outer_one;
    logic [CNT_W-1:0]  inner_load_val;

    // A line reload uses the captured count; a block start uses the live input.
    assign inner_load_val = (state == ST_IDLE) ? INNER_CNT : inner_init_q;

    blit_loop_cnt u_inner (
        .clk      (MasterClock),
        .rst_n    (RESETL),
        .load     (inner_load),
        .load_val (inner_load_val),
        .dec      (inner_dec),
        .is_one_c (inner_one)
    );

    blit_loop_cnt u_outer (
        .clk      (MasterClock),
        .rst_n    (RESETL),
        .load     (outer_load),
        .load_val (OUTER_CNT),
        .dec      (outer_dec),
        .is_one_c (outer_one)
    );

    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            state        <= ST_IDLE;
            ADDR         <= '0;
            parity_q     <= 1'b0;
            step_q       <= '0;
            yfrac_q      <= 1'b0;
            inner_init_q <= '0;
            ADDR_REQ     <= 1'b0;
            BUSY         <= 1'b0;
            LINE_END     <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            state    <= state_nxt;
            ADDR     <= addr_nxt;
            parity_q <= parity_nxt;
            if (capture) begin
                step_q       <= {STEPM1, STEP};
                yfrac_q      <= YFRAC;
                inner_init_q <= INNER_CNT;
            end
            ADDR_REQ <= (state_nxt == ST_RUN);
            BUSY     <= (state_nxt != ST_IDLE);
            LINE_END <= (state_nxt == ST_STEP);
            DONE     <= (state_nxt == ST_FIN);
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = ADDR;
        parity_nxt = parity_q;
        capture    = 1'b0;
        inner_load = 1'b0;
        inner_dec  = 1'b0;
        outer_load = 1'b0;
        outer_dec  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    state_nxt  = ST_RUN;
                    addr_nxt   = ADDR_INIT;
                    parity_nxt = 1'b0;
                    capture    = 1'b1;
                    inner_load = 1'b1;
                    outer_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    state_nxt = ST_IDLE;
                end else if (MEM_ACK) begin
                    if (inner_one) begin
                        state_nxt = ST_STEP;
                    end else begin
                        addr_nxt  = ADDR + ADDR_W'(1);
                        inner_dec = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (ABORT) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // Half-rate mode skips the line step on every other line.
                    if (!yfrac_q || parity_q) begin
                        addr_nxt = ADDR + ADDR_W'(sext_step(step_q));
                    end else begin
                        addr_nxt = ADDR + ADDR_W'(1);
                    end
                    parity_nxt = ~parity_q;
                    if (outer_one) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt  = ST_RUN;
                        outer_dec  = 1'b1;
                        inner_load = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blit_addr_seq.sv
// Self-checking bench for blit_addr_seq: directed block scenarios plus randomized blocks vs a reference model.
module tb_blit_addr_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [19:0] addr_init;
    logic [7:0]  inner_cnt;
    logic [7:0]  outer_cnt;
    logic [7:0]  step;
    logic        stepm1;
    logic        yfrac;
    logic        mem_ack;
    logic [19:0] addr;
    logic        addr_req;
    logic        busy;
    logic        line_end;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    blit_addr_seq #(.ADDR_W(20)) dut (
        .MasterClock (clk),
        .RESETL      (rst_n),
        .START       (start),
        .ABORT       (abort),
        .ADDR_INIT   (addr_init),
        .INNER_CNT   (inner_cnt),
        .OUTER_CNT   (outer_cnt),
        .STEP        (step),
        .STEPM1      (stepm1),
        .YFRAC       (yfrac),
        .MEM_ACK     (mem_ack),
        .ADDR        (addr),
        .ADDR_REQ    (addr_req),
        .BUSY        (busy),
        .LINE_END    (line_end),
        .DONE        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Runs one block. The expected address stream is computed up front from the block geometry.
    task automatic run_block(input logic [19:0] init, input logic [7:0] ic, input logic [7:0] oc,
                             input logic [8:0] st, input logic yf, input int ack_pct,
                             input int stall_from, input int stall_len, input int abort_at,
                             input int restart_at);
        logic [19:0] expq[$];
        logic [19:0] a, prev_addr;
        logic        par, ack, prev_req, prev_ack, prev_abort, full, ended;
        int          ni, no, delta, idx, lines, dones, budget;

        ni    = (ic == 8'd0) ? 256 : int'(ic);
        no    = (oc == 8'd0) ? 256 : int'(oc);
        delta = st[8] ? int'(st) - 512 : int'(st);
        a     = init;
        par   = 1'b0;
        for (int l = 0; l < no; l++) begin
            for (int e = 0; e < ni; e++) begin
                expq.push_back(a);
                if (e < ni - 1) a = a + 20'd1;
            end
            if (!yf || par) a = 20'(int'(a) + delta);
            else            a = a + 20'd1;
            par = ~par;
        end

        full   = (ack_pct >= 100) && (stall_len == 0) && (abort_at < 0);
        budget = 4 * no * (ni + 1) + 20;

        addr_init = init;
        inner_cnt = ic;
        outer_cnt = oc;
        step      = st[7:0];
        stepm1    = st[8];
        yfrac     = yf;
        mem_ack   = 1'b0;
        abort     = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;

        idx = 0; lines = 0; dones = 0; ended = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b1; prev_abort = 1'b0; prev_addr = '0;
        for (int c = 1; c <= budget; c++) begin
            abort = 1'b0;
            start = 1'b0;
            if (c == 1) begin
                chk("first_req", 32'(addr_req), 32'd1);
                chk("first_busy", 32'(busy), 32'd1);
                chk("first_addr", 32'(addr), 32'(init));
            end
            if (prev_req && !prev_ack && !prev_abort) begin
                chk("stall_req", 32'(addr_req), 32'd1);
                chk("stall_addr", 32'(addr), 32'(prev_addr));
            end
            if (line_end) begin
                lines++;
                chk("line_end_no_req", 32'(addr_req), 32'd0);
                if (full) chk("line_end_cycle", 32'(c), 32'(lines * (ni + 1)));
            end
            if (done) begin
                dones++;
                if (full) chk("done_cycle", 32'(c), 32'(no * (ni + 1) + 1));
            end
            if (!busy) begin
                if (full) chk("busy_low_cycle", 32'(c), 32'(no * (ni + 1) + 2));
                ended = 1'b1;
                break;
            end
            if ((c >= stall_from && c < stall_from + stall_len) || c == abort_at) ack = 1'b0;
            else ack = ($urandom_range(99) < 32'(ack_pct));
            mem_ack = ack;
            abort   = (c == abort_at);
            start   = (c == restart_at);
            if (addr_req && ack) begin
                if (idx < expq.size()) chk("addr", 32'(addr), 32'(expq[idx]));
                else                   chk("extra_req", 32'(idx), 32'(expq.size()));
                idx++;
            end
            prev_req   = addr_req;
            prev_ack   = ack;
            prev_abort = (c == abort_at);
            prev_addr  = addr;
            @(negedge clk);
            if (c == abort_at) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_req", 32'(addr_req), 32'd0);
                chk("abort_addr", 32'(addr), 32'(prev_addr));
            end
        end
        abort   = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;

        chk("block_terminated", 32'(ended), 32'd1);
        if (abort_at >= 0) begin
            chk("abort_no_done", 32'(dones), 32'd0);
            chk("abort_no_line_end", 32'(lines), 32'd0);
        end else begin
            chk("req_count", 32'(idx), 32'(ni * no));
            chk("line_end_count", 32'(lines), 32'(no));
            chk("done_count", 32'(dones), 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        int dones;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_ack = 1'b0;
        addr_init = '0; inner_cnt = '0; outer_cnt = '0; step = '0; stepm1 = 1'b0; yfrac = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_req", 32'(addr_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_line_end", 32'(line_end), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Positive step, START retried mid-block must be ignored.
        run_block(20'h01000, 8'd4, 8'd2, 9'h010, 1'b0, 100, 0, 0, -1, 3);
        // Negative step.
        run_block(20'h00100, 8'd2, 8'd3, 9'h1F0, 1'b0, 100, 0, 0, -1, -1);
        // Half-rate stepping.
        run_block(20'h00000, 8'd1, 8'd4, 9'h040, 1'b1, 100, 0, 0, -1, -1);
        // Zero inner count with address wrap.
        run_block(20'hFFFFF, 8'd0, 8'd1, 9'h000, 1'b0, 100, 0, 0, -1, -1);
        // Stall after the second element, then abort.
        run_block(20'h02000, 8'd4, 8'd2, 9'h010, 1'b0, 100, 3, 3, 6, -1);
        // Normal block after the abort.
        run_block(20'h03000, 8'd4, 8'd2, 9'h010, 1'b0, 100, 0, 0, -1, -1);

        // ABORT together with START in idle keeps the sequencer idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_req", 32'(addr_req), 32'd0);

        // Synchronous reset mid-block.
        addr_init = 20'h01000; inner_cnt = 8'd4; outer_cnt = 8'd2;
        step = 8'h10; stepm1 = 1'b0; yfrac = 1'b0; mem_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(addr_req), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        mem_ack = 1'b0;

        // Randomized blocks.
        for (int r = 0; r < 8; r++) begin
            run_block(20'($urandom), 8'($urandom_range(6)), 8'($urandom_range(3, 1)),
                      9'($urandom), 1'($urandom), (r % 2 == 0) ? 60 : 100, 0, 0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
